// File: rtl/apb_pkg.sv
// Shared definitions for the APB3 completer memory: state encoding, bus defaults,
// error codes and an address range helper.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int APB_DATA_W = 8;
  localparam int APB_ADDR_W = 8;
  localparam int APB_MAX_WAIT = 15;

  localparam logic ERR_OKAY  = 1'b0;
  localparam logic ERR_SLVERR = 1'b1;

  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return (addr < 32'(depth));
  endfunction

endpackage

// File: rtl/apb_completer_store.sv
// DEPTH x DATA_W storage with synchronous write, combinational read and async clear.
// Per-entry written flags exist only when APB_COMPLETER_STRICT_RD_EN is defined.
module apb_completer_store
  import apb_pkg::*;
#(
  parameter int DATA_W = APB_DATA_W,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              written_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

`ifdef APB_COMPLETER_STRICT_RD_EN
  logic [DEPTH-1:0] written_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      written_q <= '0;
    end else if (we_i) begin
      written_q[widx_i] <= 1'b1;
    end
  end

  assign written_o = written_q[ridx_i];
`else
  assign written_o = 1'b1;
`endif

endmodule

// File: rtl/apb_completer_mem.sv
// APB3 completer with a byte-wide register file and WAIT_CYCLES wait states per access.
// Define APB_COMPLETER_STRICT_RD_EN to flag reads of never-written entries with PSLVERR.
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int DATA_W      = APB_DATA_W,
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > APB_MAX_WAIT) begin : g_bad_wait
    $error("apb_completer_mem: WAIT_CYCLES must be in 0..15");
  end

  apb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              store_we_s;
  logic [DATA_W-1:0] store_rdata_s;
  logic              store_written_s;
  logic              setup_err_s;

  apb_completer_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .we_i      (store_we_s),
    .widx_i    (addr_q),
    .wdata_i   (wdata_q),
    .ridx_i    (PADDR[IDX_W-1:0]),
    .rdata_o   (store_rdata_s),
    .written_o (store_written_s)
  );

  assign setup_err_s = !addr_in_range(32'(PADDR), DEPTH) || (!PWRITE && !store_written_s);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OKAY;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    store_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR[IDX_W-1:0];
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = 4'(WAIT_CYCLES);
          err_d   = setup_err_s ? ERR_SLVERR : ERR_OKAY;
          rdata_d = (PWRITE || setup_err_s) ? '0 : store_rdata_s;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Dropping PSEL or PENABLE mid-access abandons the transfer untouched.
        if (!(PSEL && PENABLE)) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          store_we_s = write_q && !err_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign PREADY  = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign PRDATA  = PREADY ? rdata_q : '0;
  assign PSLVERR = PREADY ? err_q : 1'b0;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: three instances (0, 2 and 3 wait states) on one shared bus,
// scoreboard of expected responses checked when each transfer completes.
module tb_apb_completer_mem;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 32;
`ifdef APB_COMPLETER_STRICT_RD_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          preset;
  logic [2:0]    psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata [3];
  logic [2:0]    pready;
  logic [2:0]    pslverr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           waits;
    bit           wr;
    logic         err;
    logic [DW-1:0] data;
    string        tag;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem_m [3][DEPTH];
  bit            wr_m  [3][DEPTH];
  int            waits_of [3] = '{0, 2, 3};

  always #5 pclk = ~pclk;

  apb_completer_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_completer_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_completer_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  // Compare one observed value against its expectation and count the outcome.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer; caller is at a falling edge, returns at a falling edge with bus idle.
  task automatic xfer(input int idx, input bit wr, input int addr, input logic [DW-1:0] d,
                      input string tag);
    exp_t e;
    bit   inr;
    int   n;
    inr     = (addr < DEPTH);
    e.tag   = tag;
    e.wr    = wr;
    e.waits = waits_of[idx];
    e.err   = !inr || (!wr && STRICT && !wr_m[idx][inr ? addr : 0]);
    e.data  = (wr || e.err) ? '0 : mem_m[idx][addr];
    sb.push_back(e);
    if (wr && !e.err) begin
      mem_m[idx][addr] = d;
      wr_m[idx][addr]  = 1'b1;
    end
    psel[idx] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = AW'(addr);
    pwdata    = d;
    @(negedge pclk);
    penable = 1'b1;
    paddr   = ~paddr;
    pwdata  = ~pwdata;
    n = 0;
    while (pready[idx] !== 1'b1 && n < 20) begin
      n++;
      @(negedge pclk);
    end
    e = sb.pop_front();
    chk({e.tag, "_ready_seen"}, 32'(pready[idx]), 32'd1);
    chk({e.tag, "_waits"}, 32'(n), 32'(e.waits));
    chk({e.tag, "_pslverr"}, 32'(pslverr[idx]), 32'(e.err));
    if (!e.wr) chk({e.tag, "_prdata"}, 32'(prdata[idx]), 32'(e.data));
    @(negedge pclk);
    psel    = 3'b000;
    penable = 1'b0;
    chk({e.tag, "_ready_drop"}, 32'(pready[idx]), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < DEPTH; a++) begin
        mem_m[i][a] = '0;
        wr_m[i][a]  = 1'b0;
      end
    preset  = 1'b1;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (2) @(negedge pclk);
    chk("reset_pready", 32'(pready), 32'd0);
    chk("reset_pslverr", 32'(pslverr), 32'd0);
    chk("reset_prdata", 32'(prdata[0]), 32'd0);
    preset = 1'b0;
    @(negedge pclk);

    psel[2] = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'd5;
    pwdata  = 8'h77;
    @(negedge pclk);
    penable = 1'b1;
    n = 0;
    while (pready[2] !== 1'b1 && n < 20) begin
      n++;
      @(negedge pclk);
    end
    chk("rstmid_waits", 32'(n), 32'd3);
    chk("rstmid_ready_before", 32'(pready[2]), 32'd1);
    preset = 1'b1;
    #1;
    chk("rstmid_ready_async", 32'(pready[2]), 32'd0);
    @(negedge pclk);
    psel    = 3'b000;
    penable = 1'b0;
    preset  = 1'b0;
    @(negedge pclk);
    xfer(2, 1'b0, 5, 8'h00, "rstmid_read5");

    xfer(0, 1'b0, 7, 8'h00, "unwritten_rd7");

    xfer(0, 1'b1, 14, 8'h09, "w0_wr14");
    xfer(0, 1'b0, 14, 8'h00, "w0_rd14");

    xfer(1, 1'b1, 22, 8'h23, "w2_wr22");
    xfer(1, 1'b0, 22, 8'h00, "w2_rd22");

    xfer(0, 1'b1, 0,  8'h5A, "w0_wr0");
    xfer(0, 1'b1, 31, 8'hC3, "w0_wr31");
    xfer(0, 1'b1, 13, 8'h3C, "w0_wr13");
    xfer(0, 1'b1, 45, 8'hAA, "oor_wr45");
    xfer(0, 1'b0, 45, 8'h00, "oor_rd45");
    for (int a = 0; a < DEPTH; a++) xfer(0, 1'b0, a, 8'h00, $sformatf("sweep_rd%0d", a));

    xfer(1, 1'b1, 3, 8'h11, "abort_prewr3");
    psel[1] = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'd3;
    pwdata  = 8'h55;
    @(negedge pclk);
    penable = 1'b1;
    chk("abort_ready_wait", 32'(pready[1]), 32'd0);
    @(negedge pclk);
    psel    = 3'b000;
    penable = 1'b0;
    @(negedge pclk);
    chk("abort_idle", 32'(pready[1]), 32'd0);
    xfer(1, 1'b0, 3, 8'h00, "abort_rd3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
